// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED/ADC command controller: parameter defaults,
// host command codes and controller FSM states.
package led_ctrl_pkg;

    localparam int CHANNELS_DEF  = 35;
    localparam int ADC_LINES_DEF = 18;
    localparam int CMD_W_DEF     = 7;
    localparam int DATA_W_DEF    = 8;
    localparam int BLINK_DIV_DEF = 25000000;

    typedef enum logic [6:0] {
        CMD_ADC_SEL     = 7'h01,
        CMD_RED_ON      = 7'h02,
        CMD_RED_OFF     = 7'h03,
        CMD_GREEN_ON    = 7'h04,
        CMD_GREEN_OFF   = 7'h05,
        CMD_ALL_OFF     = 7'h06,
        CMD_RED_BLINK   = 7'h07,
        CMD_GREEN_BLINK = 7'h08
    } cmd_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_EXEC     = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous level signals into clk.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/led_cmd_ctrl.sv
// Host-strobed command controller driving red/green LED channels (with
// blinking) and a one-hot ADC select bus. One command per enable pulse.
module led_cmd_ctrl
    import led_ctrl_pkg::*;
#(
    parameter int CHANNELS  = CHANNELS_DEF,
    parameter int ADC_LINES = ADC_LINES_DEF,
    parameter int CMD_W     = CMD_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int BLINK_DIV = BLINK_DIV_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [CMD_W-1:0]     command,
    input  logic [DATA_W-1:0]    data,
    input  logic                 enable,
    output logic [CHANNELS-1:0]  rleds,
    output logic [CHANNELS-1:0]  gleds,
    output logic [ADC_LINES-1:0] adcs,
    output logic                 ack,
    output logic                 err
);

    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);

    logic                 en_sync;
    state_e               state_q, state_d;
    logic                 cap, exec;
    logic [CMD_W-1:0]     cmd_q;
    logic [DATA_W-1:0]    data_q;
    logic [31:0]          idx;
    logic                 cmd_ok;

    logic [CHANNELS-1:0]  ron_q, ron_d, rblink_q, rblink_d;
    logic [CHANNELS-1:0]  gon_q, gon_d, gblink_q, gblink_d;
    logic [ADC_LINES-1:0] adcs_q, adcs_d;
    logic [CHANNELS-1:0]  rleds_q, gleds_q;
    logic                 ack_q, err_q;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 phase_q, phase_d;
    logic                 idx_ch_ok, idx_adc_ok;
    logic [CHANNELS-1:0]  ch_mask;

    sync_2ff #(.WIDTH(1)) u_en_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (enable),
        .q_o   (en_sync)
    );

    // FSM next state: capture on strobe, execute once, then wait for strobe release.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        exec    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (en_sync) begin
                    cap     = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                exec    = 1'b1;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!en_sync) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state and command/data capture; command/data are stable while enable is high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cmd_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            if (cap) begin
                cmd_q  <= command;
                data_q <= data;
            end
        end
    end

    assign idx        = 32'(data_q);
    assign idx_ch_ok  = (idx < 32'(CHANNELS));
    assign idx_adc_ok = (idx < 32'(ADC_LINES));
    assign ch_mask    = CHANNELS'(1) << idx;

    // Command decode: compute next LED/ADC state; invalid commands leave it untouched.
    always_comb begin
        ron_d    = ron_q;
        rblink_d = rblink_q;
        gon_d    = gon_q;
        gblink_d = gblink_q;
        adcs_d   = adcs_q;
        cmd_ok   = 1'b0;
        if (exec) begin
            case (cmd_q)
                CMD_W'(CMD_ADC_SEL): if (idx_adc_ok) begin
                    adcs_d = ADC_LINES'(1) << idx;
                    cmd_ok = 1'b1;
                end
                CMD_W'(CMD_RED_ON): if (idx_ch_ok) begin
                    ron_d    = ron_q | ch_mask;
                    rblink_d = rblink_q & ~ch_mask;
                    cmd_ok   = 1'b1;
                end
                CMD_W'(CMD_RED_OFF): if (idx_ch_ok) begin
                    ron_d    = ron_q & ~ch_mask;
                    rblink_d = rblink_q & ~ch_mask;
                    cmd_ok   = 1'b1;
                end
                CMD_W'(CMD_GREEN_ON): if (idx_ch_ok) begin
                    gon_d    = gon_q | ch_mask;
                    gblink_d = gblink_q & ~ch_mask;
                    cmd_ok   = 1'b1;
                end
                CMD_W'(CMD_GREEN_OFF): if (idx_ch_ok) begin
                    gon_d    = gon_q & ~ch_mask;
                    gblink_d = gblink_q & ~ch_mask;
                    cmd_ok   = 1'b1;
                end
                CMD_W'(CMD_ALL_OFF): begin
                    ron_d    = '0;
                    rblink_d = '0;
                    gon_d    = '0;
                    gblink_d = '0;
                    adcs_d   = '0;
                    cmd_ok   = 1'b1;
                end
                CMD_W'(CMD_RED_BLINK): if (idx_ch_ok) begin
                    ron_d    = ron_q | ch_mask;
                    rblink_d = rblink_q | ch_mask;
                    cmd_ok   = 1'b1;
                end
                CMD_W'(CMD_GREEN_BLINK): if (idx_ch_ok) begin
                    gon_d    = gon_q | ch_mask;
                    gblink_d = gblink_q | ch_mask;
                    cmd_ok   = 1'b1;
                end
                default: cmd_ok = 1'b0;
            endcase
        end
    end

    // Blink timebase: phase flips each time the counter wraps.
    always_comb begin
        if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d   = cnt_q + CNT_W'(1);
            phase_d = phase_q;
        end
    end

    // State registers and outputs; LEDs use next-state values so a command and
    // a phase flip in the same cycle both appear at the output together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ron_q    <= '0;
            rblink_q <= '0;
            gon_q    <= '0;
            gblink_q <= '0;
            adcs_q   <= '0;
            rleds_q  <= '0;
            gleds_q  <= '0;
            ack_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
            phase_q  <= 1'b0;
        end else begin
            ron_q    <= ron_d;
            rblink_q <= rblink_d;
            gon_q    <= gon_d;
            gblink_q <= gblink_d;
            adcs_q   <= adcs_d;
            rleds_q  <= ron_d & ~(rblink_d & {CHANNELS{phase_d}});
            gleds_q  <= gon_d & ~(gblink_d & {CHANNELS{phase_d}});
            ack_q    <= exec & cmd_ok;
            err_q    <= exec & ~cmd_ok;
            cnt_q    <= cnt_d;
            phase_q  <= phase_d;
        end
    end

    assign rleds = rleds_q;
    assign gleds = gleds_q;
    assign adcs  = adcs_q;
    assign ack   = ack_q;
    assign err   = err_q;

endmodule

// File: tb/tb_led_cmd_ctrl.sv
// Self-checking bench for led_cmd_ctrl with a fast blink divider.
module tb_led_cmd_ctrl;

    localparam int CH  = 35;
    localparam int AL  = 18;
    localparam int CW  = 7;
    localparam int DW  = 8;
    localparam int DIV = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CW-1:0] command = '0;
    logic [DW-1:0] data = '0;
    logic          enable = 1'b0;
    logic [CH-1:0] rleds, gleds;
    logic [AL-1:0] adcs;
    logic          ack, err;

    int total = 0;
    int bad = 0;
    int ecnt;

    // Reference model state
    logic [CH-1:0] m_ron = '0, m_rbl = '0, m_gon = '0, m_gbl = '0;
    logic [AL-1:0] m_adc = '0;

    led_cmd_ctrl #(
        .CHANNELS(CH), .ADC_LINES(AL), .CMD_W(CW), .DATA_W(DW), .BLINK_DIV(DIV)
    ) dut (
        .clk(clk), .rst_n(rst_n), .command(command), .data(data), .enable(enable),
        .rleds(rleds), .gleds(gleds), .adcs(adcs), .ack(ack), .err(err)
    );

    always #5 clk = ~clk;

    // Clock edges elapsed since reset release; blink phase follows from it.
    always @(posedge clk or negedge rst_n)
        if (!rst_n) ecnt <= 0;
        else        ecnt <= ecnt + 1;

    function automatic logic ph();
        return ((ecnt / DIV) % 2) == 1;
    endfunction

    function automatic logic [CH-1:0] exp_r();
        return m_ron & ~(m_rbl & {CH{ph()}});
    endfunction

    function automatic logic [CH-1:0] exp_g();
        return m_gon & ~(m_gbl & {CH{ph()}});
    endfunction

    function automatic bit model_apply(input int c, input int d);
        logic [CH-1:0] m;
        m = '0;
        if (d < CH) m[d] = 1'b1;
        case (c)
            1: if (d < AL) begin m_adc = '0; m_adc[d] = 1'b1; return 1; end
            2: if (d < CH) begin m_ron |= m; m_rbl &= ~m; return 1; end
            3: if (d < CH) begin m_ron &= ~m; m_rbl &= ~m; return 1; end
            4: if (d < CH) begin m_gon |= m; m_gbl &= ~m; return 1; end
            5: if (d < CH) begin m_gon &= ~m; m_gbl &= ~m; return 1; end
            6: begin m_ron = '0; m_rbl = '0; m_gon = '0; m_gbl = '0; m_adc = '0; return 1; end
            7: if (d < CH) begin m_ron |= m; m_rbl |= m; return 1; end
            8: if (d < CH) begin m_gon |= m; m_gbl |= m; return 1; end
            default: return 0;
        endcase
        return 0;
    endfunction

    function automatic void model_reset();
        m_ron = '0; m_rbl = '0; m_gon = '0; m_gbl = '0; m_adc = '0;
    endfunction

    // One full host transaction: strobe, expect result on edge 4, hold, release.
    task automatic run_cmd(input int c, input int d, input int hold);
        bit ok;
        @(negedge clk);
        command = c[CW-1:0];
        data    = d[DW-1:0];
        enable  = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clk); #1;
            total++;
            if ({ack, err} !== 2'b00 || {rleds, gleds, adcs} !== {exp_r(), exp_g(), m_adc}) begin
                bad++;
                $display("FAIL pre_exec cmd=%0h d=%0d edge=%0d ack=%b err=%b r=%h g=%h a=%h exp r=%h g=%h a=%h",
                         c, d, e, ack, err, rleds, gleds, adcs, exp_r(), exp_g(), m_adc);
            end
        end
        @(posedge clk); #1;
        ok = model_apply(c, d);
        total++;
        if ({ack, err} !== {ok, !ok}) begin
            bad++;
            $display("FAIL ack_err cmd=%0h d=%0d got ack=%b err=%b exp ack=%b err=%b", c, d, ack, err, ok, !ok);
        end
        total++;
        if ({rleds, gleds, adcs} !== {exp_r(), exp_g(), m_adc}) begin
            bad++;
            $display("FAIL apply cmd=%0h d=%0d r=%h g=%h a=%h exp r=%h g=%h a=%h",
                     c, d, rleds, gleds, adcs, exp_r(), exp_g(), m_adc);
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            total++;
            if ({ack, err} !== 2'b00 || {rleds, gleds, adcs} !== {exp_r(), exp_g(), m_adc}) begin
                bad++;
                $display("FAIL hold cmd=%0h cyc=%0d ack=%b err=%b r=%h g=%h exp r=%h g=%h",
                         c, i, ack, err, rleds, gleds, exp_r(), exp_g());
            end
        end
        @(negedge clk);
        enable = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            total++;
            if ({ack, err} !== 2'b00) begin
                bad++;
                $display("FAIL release cmd=%0h ack=%b err=%b exp 00", c, ack, err);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({rleds, gleds, adcs, ack, err} !== '0) begin
            bad++;
            $display("FAIL reset_state r=%h g=%h a=%h ack=%b err=%b exp all 0", rleds, gleds, adcs, ack, err);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_red_on();
        logic [CH-1:0] e;
        e = '0; e[5] = 1'b1;
        run_cmd(2, 5, 2);
        total++;
        if (rleds !== e) begin
            bad++;
            $display("FAIL red_on5 rleds=%h exp=%h", rleds, e);
        end
    endtask

    task automatic test_adc_sel();
        logic [AL-1:0] e;
        e = '0; e[17] = 1'b1;
        run_cmd(1, 17, 0);
        total++;
        if (adcs !== e) begin bad++; $display("FAIL adc17 adcs=%h exp=%h", adcs, e); end
        run_cmd(1, 18, 0);
        total++;
        if (adcs !== e) begin bad++; $display("FAIL adc18_unchanged adcs=%h exp=%h", adcs, e); end
    endtask

    task automatic test_blink();
        logic prev;
        int tog;
        run_cmd(8, 0, 0);
        prev = gleds[0];
        tog  = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            total++;
            if (gleds !== exp_g()) begin
                bad++;
                $display("FAIL blink cyc=%0d gleds=%h exp=%h", i, gleds, exp_g());
            end
            if (gleds[0] !== prev) tog++;
            prev = gleds[0];
        end
        total++;
        if (tog !== 4) begin bad++; $display("FAIL blink_toggles got=%0d exp=4", tog); end
        run_cmd(4, 0, 0);
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            total++;
            if (gleds[0] !== 1'b1) begin bad++; $display("FAIL steady_green cyc=%0d got=%b exp=1", i, gleds[0]); end
        end
    endtask

    task automatic test_bad_hold();
        logic [CH-1:0] sr, sg;
        logic [AL-1:0] sa;
        sr = rleds; sg = gleds; sa = adcs;
        run_cmd(9, 3, 100);
        total++;
        if ({rleds, gleds, adcs} !== {sr, sg, sa}) begin
            bad++;
            $display("FAIL bad_cmd_state r=%h g=%h a=%h exp r=%h g=%h a=%h", rleds, gleds, adcs, sr, sg, sa);
        end
        run_cmd(7, 30, 50);
    endtask

    task automatic test_all_on_off();
        run_cmd(6, 0, 0);
        for (int i = 0; i < CH; i++) run_cmd(2, i, 0);
        total++;
        if (rleds !== {CH{1'b1}}) begin bad++; $display("FAIL all_red rleds=%h exp all ones", rleds); end
        run_cmd(6, 200, 0);
        total++;
        if ({rleds, gleds, adcs} !== '0) begin
            bad++;
            $display("FAIL all_off r=%h g=%h a=%h exp 0", rleds, gleds, adcs);
        end
    endtask

    task automatic test_reset_exec();
        run_cmd(2, 9, 0);
        run_cmd(1, 3, 0);
        @(negedge clk);
        command = 7'h02; data = 8'd10; enable = 1'b1;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({rleds, gleds, adcs, ack, err} !== '0) begin
            bad++;
            $display("FAIL async_reset r=%h g=%h a=%h ack=%b err=%b exp 0", rleds, gleds, adcs, ack, err);
        end
        model_reset();
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if ({rleds, gleds, adcs, ack, err} !== '0) begin
                bad++;
                $display("FAIL post_reset cyc=%0d r=%h ack=%b err=%b exp 0", i, rleds, ack, err);
            end
        end
    endtask

    task automatic test_release_high();
        bit ok;
        @(negedge clk);
        rst_n = 1'b0;
        command = 7'h02; data = 8'd12; enable = 1'b1;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({ack, err} !== 2'b00) begin bad++; $display("FAIL rel_high_early ack=%b err=%b exp 00", ack, err); end
        @(posedge clk); #1;
        ok = model_apply(2, 12);
        total++;
        if ({ack, err, rleds} !== {ok, 1'b0, exp_r()}) begin
            bad++;
            $display("FAIL rel_high_exec ack=%b err=%b r=%h exp ack=1 err=0 r=%h", ack, err, rleds, exp_r());
        end
        @(negedge clk);
        enable = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++)
            run_cmd($urandom_range(0, 10), $urandom_range(0, 40), $urandom_range(0, 5));
    endtask

    initial begin
        test_reset();
        test_red_on();
        test_adc_sel();
        test_blink();
        test_bad_hold();
        test_all_on_off();
        test_reset_exec();
        test_release_high();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_cmd_ctrl.md
LED_CMD_CTRL -- requirements
Module: led_cmd_ctrl

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning):
- CHANNELS, 35, LED channel count (1..256).
- ADC_LINES, 18, one-hot ADC select line count (1..256).
- CMD_W, 7, command width.
- DATA_W, 8, data width.
- BLINK_DIV, 25000000, clock cycles per blink half-period (>=2).

REQ-002 The block SHALL expose these ports (name, direction, width, meaning):
- clk, in, 1, sole clock, rising edge.
- rst_n, in, 1, asynchronous active-low reset.
- command, in, CMD_W, command code from host, stable while enable is high.
- data, in, DATA_W, channel index, stable while enable is high.
- enable, in, 1, asynchronous host strobe; a rising edge requests execution.
- rleds, out, CHANNELS, red LED drive, registered.
- gleds, out, CHANNELS, green LED drive, registered.
- adcs, out, ADC_LINES, one-hot ADC select, registered.
- ack, out, 1, one-cycle pulse when a valid command is applied.
- err, out, 1, one-cycle pulse when a command is rejected.

Function
REQ-003 The enable input SHALL pass through a 2-flop synchroniser; command and data SHALL NOT be synchronised and SHALL be captured only on the detected strobe.
REQ-004 The FSM SHALL have three states:
- IDLE: on synchronised enable high, capture command/data and go to EXEC.
- EXEC: apply the command, pulse ack or err, go to WAIT_LOW.
- WAIT_LOW: stay until synchronised enable is low, then go to IDLE.
REQ-005 Outputs and ack/err SHALL update on the 4th rising clk edge, counting the first edge that samples enable high as edge 1.
REQ-006 Holding enable high for any duration SHALL execute exactly one command; enable must return low before the next command is accepted.
REQ-007 Command codes SHALL be:
- 0x01 ADC_SEL: adcs = one-hot bit data.
- 0x02 RED_ON: red on bit set, red blink bit cleared.
- 0x03 RED_OFF: red on bit cleared, red blink bit cleared.
- 0x04 GREEN_ON: green on bit set, green blink bit cleared.
- 0x05 GREEN_OFF: green on bit cleared, green blink bit cleared.
- 0x06 ALL_OFF: every on, blink and adcs bit cleared; data ignored.
- 0x07 RED_BLINK: red on bit and red blink bit set.
- 0x08 GREEN_BLINK: green on bit and green blink bit set.
REQ-008 Any other command code, data >= CHANNELS on an LED command, or data >= ADC_LINES on ADC_SEL SHALL leave all state unchanged and pulse err instead of ack.
REQ-009 A free-running counter SHALL count 0..BLINK_DIV-1, wrap to 0, and toggle a phase bit on wrap; phase resets to 0 (LEDs lit).
REQ-010 The LED outputs SHALL be registered as: rleds[i] = ron[i] & ~(rblink[i] & phase), and gleds the same with the green registers.
REQ-011 A command applied in the same cycle as a phase toggle SHALL take both effects; neither SHALL be dropped or delayed.
REQ-012 ack and err SHALL never be high in the same cycle, and each SHALL be high for exactly one cycle per command.
REQ-013 Red and green state SHALL be independent; both colours on one channel is legal.

Reset
REQ-014 While rst_n is low, the block SHALL asynchronously clear all outputs, on and blink registers, the blink counter, phase and synchroniser flops, and force the FSM to IDLE.
REQ-015 A command in flight when reset asserts SHALL be discarded.
REQ-016 After reset release, if enable is already high, the block SHALL execute it as a new command.

Structure
REQ-017 Package led_ctrl_pkg SHALL hold the command-code enum, the FSM state enum and the parameter defaults.
REQ-018 Sub-module sync_2ff (parametrised 2-flop synchroniser, async active-low reset) SHALL synchronise enable.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- RED_ON data=5 -> rleds=1<<5 on edge 4, ack for one cycle, err=0.
- ADC_SEL data=17, then data=18 -> adcs=1<<17, ack; then adcs unchanged, err pulse.
- With BLINK_DIV=4, GREEN_BLINK data=0 -> gleds[0] toggles every 4 cycles; GREEN_ON data=0 -> steady 1.
- Command 0x09, then enable held high 100 cycles -> err once, no state change; a single execution only.
- RED_ON 0..34, then ALL_OFF -> rleds all ones, then rleds=gleds=adcs=0.
- rst_n low during EXEC -> all outputs 0 asynchronously, no ack after release.
